// File: rtl/bicubic_stream_packer.sv
// Packs limited bicubic output beats into an AXI4-Stream video stream with frame/line tags,
// a small FIFO, a registered output stage and a clock-enable throttle back to the pipeline.
module bicubic_stream_packer #(
    parameter int OUTPUT_WIDTH  = 3840,
    parameter int OUTPUT_HEIGHT = 2160,
    parameter int PIXEL_PER_CLK = 4,
    parameter int FIFO_DEPTH    = 16,
    parameter int SKID_SLOTS    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic [PIXEL_PER_CLK*8-1:0]   pixel_in,
    input  logic                         pixel_valid,
    output logic                         pipe_clken,
    output logic [PIXEL_PER_CLK*8-1:0]   m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tuser,
    output logic                         m_axis_tlast,
    output logic                         frame_done,
    output logic                         overflow
);
    localparam int BPL = OUTPUT_WIDTH / PIXEL_PER_CLK;
    localparam int DW  = PIXEL_PER_CLK * 8;
    localparam int EW  = DW + 3;
    localparam int XW  = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int YW  = (OUTPUT_HEIGHT > 1) ? $clog2(OUTPUT_HEIGHT) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [XW-1:0] X_LAST  = XW'(BPL - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(OUTPUT_HEIGHT - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    generate
        if (OUTPUT_WIDTH % PIXEL_PER_CLK != 0) begin : g_bad_bpl
            $error("OUTPUT_WIDTH must be a multiple of PIXEL_PER_CLK");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [XW-1:0] x_cnt_reg, x_cnt_next, x_eff;
    logic [YW-1:0] y_cnt_reg, y_cnt_next, y_eff;
    logic          tag_user, tag_last, tag_eof;
    logic [EW-1:0] wr_entry;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          push, pop;
    logic [EW-1:0] head_next;

    logic [EW-1:0] out_entry_reg;
    logic          out_valid_reg;
    logic          frame_done_reg;
    logic          overflow_reg;
    logic          pipe_clken_reg;

    // frame_start forces this cycle's beat to (0,0); counting resumes from there
    always_comb begin
        x_eff      = frame_start ? '0 : x_cnt_reg;
        y_eff      = frame_start ? '0 : y_cnt_reg;
        x_cnt_next = x_eff;
        y_cnt_next = y_eff;
        if (pixel_valid) begin
            if (x_eff == X_LAST) begin
                x_cnt_next = '0;
                y_cnt_next = (y_eff == Y_LAST) ? '0 : y_eff + 1'b1;
            end else begin
                x_cnt_next = x_eff + 1'b1;
            end
        end
    end

    assign tag_user = (x_eff == '0) && (y_eff == '0);
    assign tag_last = (x_eff == X_LAST);
    assign tag_eof  = tag_last && (y_eff == Y_LAST);
    assign wr_entry = {tag_eof, tag_last, tag_user, pixel_in};

    // The head entry stays in memory until popped; the output register mirrors it
    assign pop         = out_valid_reg && m_axis_tready;
    assign push        = pixel_valid && ((count_reg < DEPTH_C) || pop);
    assign rd_ptr_next = rd_ptr_reg + AW'(pop);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Write-through when the beat being written becomes the new head (empty or draining to it)
    assign head_next = (push && (wr_ptr_reg == rd_ptr_next)) ? wr_entry : mem[rd_ptr_next];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt_reg      <= '0;
            y_cnt_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            out_entry_reg  <= '0;
            out_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            pipe_clken_reg <= 1'b0;
        end else begin
            x_cnt_reg      <= x_cnt_next;
            y_cnt_reg      <= y_cnt_next;
            wr_ptr_reg     <= wr_ptr_reg + AW'(push);
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            out_valid_reg  <= (count_next != '0);
            if (count_next != '0) begin
                out_entry_reg <= head_next;
            end
            frame_done_reg <= pop && out_entry_reg[EW-1];
            if (pixel_valid && !push) begin
                overflow_reg <= 1'b1;
            end
            pipe_clken_reg <= (FIFO_DEPTH - int'(count_next)) > SKID_SLOTS;
        end
    end

    assign m_axis_tdata  = out_entry_reg[DW-1:0];
    assign m_axis_tuser  = out_entry_reg[DW];
    assign m_axis_tlast  = out_entry_reg[DW+1];
    assign m_axis_tvalid = out_valid_reg;
    assign frame_done    = frame_done_reg;
    assign overflow      = overflow_reg;
    assign pipe_clken    = pipe_clken_reg;
endmodule

// File: doc/bicubic_stream_packer.md
BICUBIC_STREAM_PACKER -- requirements
Module: bicubic_stream_packer

Interface
REQ-001 SHALL have parameters, one per line:
- OUTPUT_WIDTH, 3840, output pixels per line.
- OUTPUT_HEIGHT, 2160, output lines per frame.
- PIXEL_PER_CLK, 4, pixels per beat.
- FIFO_DEPTH, 16, beats of storage, power of 2.
- SKID_SLOTS, 8, free slots reserved for pipeline in-flight beats.

REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  pulse; next accepted beat is frame pixel (0,0).
- pixel_in  in  PIXEL_PER_CLK*8  limited pixels from the bicubic pipeline; pixel k at [8k+7:8k], k=0 leftmost.
- pixel_valid  in  1  pixel_in carries a valid beat this cycle.
- pipe_clken  out  1  clock enable back to the bicubic pipeline.
- m_axis_tdata  out  PIXEL_PER_CLK*8  AXI4-Stream video data.
- m_axis_tvalid  out  1  data valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  start of frame.
- m_axis_tlast  out  1  end of line.
- frame_done  out  1  one-cycle pulse, frame fully delivered.
- overflow  out  1  sticky, a beat was dropped.

REQ-003 SHALL use one clock (clk) and a synchronous active-high reset (reset); there SHALL be no asynchronous reset.

Function
REQ-004 SHALL define BPL = OUTPUT_WIDTH/PIXEL_PER_CLK; non-integer BPL SHALL be an elaboration error.
REQ-005 SHALL keep write-side counters x_cnt (0..BPL-1) and y_cnt (0..OUTPUT_HEIGHT-1).
REQ-006 SHALL advance x_cnt on every cycle with pixel_valid=1. At BPL-1, x_cnt SHALL wrap to 0 and y_cnt SHALL increment. y_cnt SHALL wrap to 0 after OUTPUT_HEIGHT-1.
REQ-007 SHALL tag each written beat:
- user = (x_cnt==0 && y_cnt==0).
- last = (x_cnt==BPL-1).
- eof = last && (y_cnt==OUTPUT_HEIGHT-1).
REQ-008 SHALL store {eof, last, user, data} in a FIFO of FIFO_DEPTH entries.
REQ-009 When frame_start=1, the counters SHALL be treated as 0 for that cycle's beat (if pixel_valid=1) and SHALL then continue from there. FIFO contents SHALL NOT be flushed.
REQ-010 A write SHALL be accepted when occupancy < FIFO_DEPTH, or when a pop occurs in the same cycle.
REQ-011 When a write is refused, the beat SHALL be dropped, overflow SHALL set to 1 and stay 1 until reset, and the counters SHALL still advance to preserve geometry.
REQ-012 Output side:
- m_axis_tvalid = FIFO non-empty, presented from an output register.
- A beat written in cycle N SHALL be visible on m_axis_* no earlier than cycle N+1.
REQ-013 A pop SHALL occur only when m_axis_tvalid && m_axis_tready.
REQ-014 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tuser and m_axis_tlast SHALL hold stable.
REQ-015 Beats SHALL leave in write order; no beat SHALL be duplicated or reordered.
REQ-016 frame_done SHALL pulse high for exactly one cycle, the cycle after the handshake of an eof-tagged beat.
REQ-017 pipe_clken SHALL be registered and equal 1 when (FIFO_DEPTH - occupancy) > SKID_SLOTS, otherwise 0.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged, including at full and at empty with a bypass to the output register.

Reset
REQ-019 While reset=1, the block SHALL hold:
- x_cnt=0, y_cnt=0, FIFO empty.
- m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0.
- frame_done=0, overflow=0, pipe_clken=0.
REQ-020 pipe_clken SHALL be 1 in the first cycle after reset deasserts.
REQ-021 Reset asserted mid-frame SHALL discard all stored beats; the next accepted beat after reset SHALL be pixel (0,0).

Verification
Directed scenarios use OUTPUT_WIDTH=16, OUTPUT_HEIGHT=2, FIFO_DEPTH=16, SKID_SLOTS=8, so BPL=4 and 8 beats per frame.
REQ-022 Basic frame: 8 consecutive valid beats with tready=1 -> tuser=1 on beat 0 only, tlast on beats 3 and 7, frame_done one cycle after beat 7 handshake, overflow=0.
REQ-023 Backpressure: tready=0 for 20 cycles during 12 pushed beats -> pipe_clken falls when occupancy reaches 8, data stable while stalled, all 12 beats delivered in order after tready=1.
REQ-024 Overflow: 17 beats pushed with tready=0 -> beat 17 dropped, overflow=1 sticky, delivered beats are 1..16, tlast positions still follow the counter.
REQ-025 Resync: frame_start with pixel_valid at x_cnt=2 -> that beat carries tuser=1, and tlast falls 3 beats later.
REQ-026 Reset mid-frame: reset after 5 beats with 2 still queued -> tvalid=0 the next cycle, and the next beat carries tuser=1.
REQ-027 Full boundary: push and pop in the same cycle at occupancy 16 -> write accepted, occupancy stays 16, overflow stays 0.
